pipeline_hazard_controller: RTL

- Central stall/flush sequencer for the 5-stage pipeline.
- Detects RAW data hazards in ID and drives hazard_detected into the control unit, which zeroes EXE_CMD, WB_EN and MEM_W_EN.
- Flushes the wrong-path instructions on a taken branch.
- Freezes the whole pipeline while a MEM-stage SRAM access is outstanding, using a small FSM with timeout and stall statistics.

---
 rtl/pipeline_hazard_controller_pkg.sv | 18 +
 rtl/pipeline_hazard_controller_if.sv | 47 ++++
 rtl/pipeline_hazard_controller_hazard_compare.sv | 41 ++++
 rtl/pipeline_hazard_controller.sv | 119 +++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_hazard_controller_pkg;

    // Memory-access sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    localparam int REG_AW_DEF = 5;

    // Architectural zero register: writes to it are discarded, so it never creates a dependency
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of pipeline-side signals exchanged with the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: freeze/flush outputs are the pipeline's stall controls.
//   master: pipeline stages (drive ID/EXE/MEM state, consume stall controls)
//   slave : hazard controller
interface pipeline_hazard_controller_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              forward_en;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_two_src;
    logic [REG_AW-1:0] exe_dest;
    logic              exe_wb_en;
    logic              exe_mem_r_en;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_wb_en;
    logic              mem_req;
    logic              branch_taken;
    logic              sram_ready;

    logic              hazard_detected;
    logic              freeze_pc;
    logic              freeze_if_id;
    logic              flush_if_id;
    logic              flush_id_exe;
    logic              freeze_all;
    logic              sram_start;
    logic              mem_error;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output forward_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
               exe_mem_r_en, mem_dest, mem_wb_en, mem_req, branch_taken, sram_ready,
        input  hazard_detected, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe,
               freeze_all, sram_start, mem_error, stall_count
    );

    modport slave (
        input  forward_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
               exe_mem_r_en, mem_dest, mem_wb_en, mem_req, branch_taken, sram_ready,
        output hazard_detected, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe,
               freeze_all, sram_start, mem_error, stall_count
    );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_compare.sv
// RAW dependency check between the ID sources and the EXE/MEM destinations.
// Latency: purely combinational.
// Backpressure: none; result feeds the stall priority logic in the top.
//   in : i_forward_en, i_id_src1/2, i_id_two_src, i_exe_dest/wb_en/mem_r_en, i_mem_dest/wb_en
//   out: o_hazard
module pipeline_hazard_controller_hazard_compare
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_forward_en,
    input  logic [REG_AW-1:0] i_id_src1,
    input  logic [REG_AW-1:0] i_id_src2,
    input  logic              i_id_two_src,
    input  logic [REG_AW-1:0] i_exe_dest,
    input  logic              i_exe_wb_en,
    input  logic              i_exe_mem_r_en,
    input  logic [REG_AW-1:0] i_mem_dest,
    input  logic              i_mem_wb_en,
    output logic              o_hazard
);

    logic w_exe_live;
    logic w_mem_live;
    logic w_exe_dep;
    logic w_mem_dep;

    // A producer only matters if it actually writes a non-zero register
    assign w_exe_live = i_exe_wb_en && (i_exe_dest != REG_AW'(REG_ZERO));
    assign w_mem_live = i_mem_wb_en && (i_mem_dest != REG_AW'(REG_ZERO));

    assign w_exe_dep = w_exe_live &&
                       ((i_id_src1 == i_exe_dest) || (i_id_two_src && (i_id_src2 == i_exe_dest)));
    assign w_mem_dep = w_mem_live &&
                       ((i_id_src1 == i_mem_dest) || (i_id_two_src && (i_id_src2 == i_mem_dest)));

    // With forwarding, only a load in EXE cannot be bypassed in time
    assign o_hazard = i_forward_en ? (i_exe_mem_r_en && w_exe_dep)
                                   : (w_exe_dep || w_mem_dep);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: RAW stalls, taken-branch flushes, and a MEM-access freeze FSM.
// Latency: stall/flush controls combinational; mem_error/stall_count registered.
// Backpressure: freeze_all holds the whole pipeline while an SRAM access is outstanding.
//   in : clk, rst, bus (slave) carrying ID/EXE/MEM operand info, mem_req, branch_taken, sram_ready
//   out: bus hazard_detected, freeze_pc/if_id, flush_if_id/id_exe, freeze_all, sram_start,
//        mem_error, stall_count
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_controller_if.slave  bus
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_nxt;
    logic               r_mem_error;
    logic               w_mem_error_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_raw_hazard;
    logic               w_fsm_freeze;
    logic               w_fsm_start;
    logic               w_freeze_all;
    logic               w_flush;
    logic               w_hazard;

    pipeline_hazard_controller_hazard_compare #(
        .REG_AW (REG_AW)
    ) u_hazard_compare (
        .i_forward_en   (bus.forward_en),
        .i_id_src1      (bus.id_src1),
        .i_id_src2      (bus.id_src2),
        .i_id_two_src   (bus.id_two_src),
        .i_exe_dest     (bus.exe_dest),
        .i_exe_wb_en    (bus.exe_wb_en),
        .i_exe_mem_r_en (bus.exe_mem_r_en),
        .i_mem_dest     (bus.mem_dest),
        .i_mem_wb_en    (bus.mem_wb_en),
        .o_hazard       (w_raw_hazard)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_mem_error_nxt = r_mem_error;
        w_fsm_freeze    = 1'b0;
        w_fsm_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_req) begin
                    w_fsm_freeze   = 1'b1;
                    w_fsm_start    = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                w_fsm_freeze   = 1'b1;
                w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                if (bus.sram_ready) begin
                    w_state_nxt = RELEASE;
                end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    // Give up on the SRAM so the core cannot deadlock; flag it stickily
                    w_state_nxt     = RELEASE;
                    w_mem_error_nxt = 1'b1;
                end
            end
            RELEASE: begin
                // Unfrozen for exactly one cycle so the MEM instruction retires
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Priority: memory freeze masks everything; a taken branch discards the ID
    // instruction, so any dependency it had is moot
    assign w_freeze_all = !rst && w_fsm_freeze;
    assign w_flush      = !rst && !w_fsm_freeze && bus.branch_taken;
    assign w_hazard     = !rst && !w_fsm_freeze && !bus.branch_taken && w_raw_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_error <= w_mem_error_nxt;
            if ((w_freeze_all || w_hazard) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.hazard_detected = w_hazard;
    assign bus.freeze_pc       = w_hazard;
    assign bus.freeze_if_id    = w_hazard;
    assign bus.flush_if_id     = w_flush;
    assign bus.flush_id_exe    = w_flush;
    assign bus.freeze_all      = w_freeze_all;
    assign bus.sram_start      = !rst && w_fsm_start;
    assign bus.mem_error       = r_mem_error;
    assign bus.stall_count     = r_stall_cnt;

endmodule
